tb_obi_delay: RTL and testbench

- Testbench-only OBI latency injector between a core OBI master port (instruction or data) and one port of the zero-wait OBI RAM model.
- Stretches grant and response timing by configurable fixed or pseudo-random amounts, so core stall paths are exercised.
- Preserves OBI ordering and payload integrity.
- One instance per core port.

---
 rtl/tb_obi_pkg.sv | 33 +++
 rtl/tb_obi_response_fifo.sv | 47 ++++
 rtl/tb_obi_delay.sv | 161 ++++++++++++++++
 tb/tb_tb_obi_delay.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tb_obi_pkg.sv
// Shared types and constants for the OBI latency injector.
package tb_obi_pkg;

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } obi_req_t;

   typedef struct packed {
      logic [31:0] rdata;
   } obi_rsp_t;

   typedef struct packed {
      obi_rsp_t    rsp;
      logic [15:0] ts;
   } rsp_entry_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_ISSUE = 2'd2
   } gnt_state_t;

   // Galois form of x^16 + x^14 + x^13 + x^11 + 1, shifting right.
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
   endfunction

endpackage

// File: rtl/tb_obi_response_fifo.sv
// In-order response buffer for the latency injector; pure storage, no timing decisions.
module tb_obi_response_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 48,
   localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          i_push,
   input  logic [W-1:0]  i_data,
   input  logic          i_pop,
   output logic [W-1:0]  o_head,
   output logic [CW-1:0] o_count,
   output logic          o_empty
);

   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wr;
   logic [PW-1:0] r_rd;
   logic [CW-1:0] r_count;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_wr <= ptr_inc(r_wr);
         if (i_pop)  r_rd <= ptr_inc(r_rd);
         r_count <= r_count + CW'(i_push) - CW'(i_pop);
      end
   end

   always_ff @(posedge clock) begin
      if (i_push) r_mem[r_wr] <= i_data;
   end

   assign o_head  = r_mem[r_rd];
   assign o_count = r_count;
   assign o_empty = (r_count == '0);

endmodule

// File: rtl/tb_obi_delay.sv
// OBI latency injector between a core port and a zero-wait RAM port.
// state    | meaning
// ST_IDLE  | no request pending; a new request draws its grant delay here
// ST_WAIT  | counting down the drawn delay, core must hold req
// ST_ISSUE | forwarding req to RAM, gated by the outstanding limit
module tb_obi_delay
   import tb_obi_pkg::*;
#(
   parameter int          GNT_DELAY       = 0,
   parameter int          RVALID_DELAY    = 0,
   parameter int          MAX_OUTSTANDING = 2,
   parameter int          RANDOM          = 0,
   parameter logic [15:0] SEED            = 16'hACE1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        up_req,
   input  logic [31:0] up_addr,
   input  logic        up_we,
   input  logic [3:0]  up_be,
   input  logic [31:0] up_wdata,
   output logic        up_gnt,
   output logic [31:0] up_rdata,
   output logic        up_rvalid,
   output logic        dn_req,
   output logic [31:0] dn_addr,
   output logic        dn_we,
   output logic [3:0]  dn_be,
   output logic [31:0] dn_wdata,
   input  logic        dn_gnt,
   input  logic [31:0] dn_rdata,
   input  logic        dn_rvalid,
   output logic        protocol_error
);

   localparam int          CW   = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [15:0] GD   = 16'(GNT_DELAY);
   localparam logic [15:0] RD   = 16'(RVALID_DELAY);
   localparam logic [4:0]  MAXO = 5'(MAX_OUTSTANDING);

   gnt_state_t    r_state, w_state_nxt;
   logic [15:0]   r_cnt, w_cnt_nxt;
   logic [15:0]   r_lfsr, r_now, w_d, w_age;
   logic [4:0]    r_outst, w_pending;
   logic          r_perr, w_perr_fsm, w_can, w_dn_req, w_accept;
   logic          w_stale, w_bypass, w_release, w_push, w_fifo_empty;
   logic [CW-1:0] w_fifo_count;
   rsp_entry_t    w_push_entry, w_head;
   logic [31:0]   r_rdata_hold;
   obi_req_t      w_req;

   assign w_req    = '{addr: up_addr, we: up_we, be: up_be, wdata: up_wdata};
   assign dn_addr  = w_req.addr;
   assign dn_we    = w_req.we;
   assign dn_be    = w_req.be;
   assign dn_wdata = w_req.wdata;

   always_comb begin
      w_d = GD;
      if (RANDOM != 0 && {8'h00, r_lfsr[7:0]} < GD) w_d = {8'h00, r_lfsr[7:0]};
   end

   assign w_can = (r_outst < MAXO);

   // The IDLE cycle itself counts as the first waited cycle, so WAIT is loaded
   // with d-1 and a delay of 1 skips WAIT entirely.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_dn_req    = 1'b0;
      w_perr_fsm  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (up_req) begin
               if (w_d == 16'd0) begin
                  w_dn_req = w_can;
                  if (!(w_can && dn_gnt)) w_state_nxt = ST_ISSUE;
               end else if (w_d == 16'd1) begin
                  w_state_nxt = ST_ISSUE;
               end else begin
                  w_cnt_nxt   = w_d - 16'd1;
                  w_state_nxt = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (!up_req) begin
               w_perr_fsm  = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (r_cnt == 16'd1) begin
               w_state_nxt = ST_ISSUE;
            end else begin
               w_cnt_nxt = r_cnt - 16'd1;
            end
         end
         ST_ISSUE: begin
            if (!up_req) begin
               w_perr_fsm  = 1'b1;
               w_state_nxt = ST_IDLE;
            end else begin
               w_dn_req = w_can;
               if (w_can && dn_gnt) w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign dn_req   = w_dn_req & ~reset;
   assign up_gnt   = dn_req & dn_gnt;
   assign w_accept = up_gnt;

   // Transactions still waiting for the RAM; a response with none pending is stale.
   assign w_pending    = r_outst - 5'(w_fifo_count);
   assign w_stale      = dn_rvalid & (w_pending == 5'd0) & ~reset;
   assign w_bypass     = (RVALID_DELAY == 0) & w_fifo_empty & dn_rvalid & ~w_stale & ~reset;
   assign w_push       = dn_rvalid & ~w_stale & ~w_bypass & ~reset;
   assign w_push_entry = '{rsp: '{rdata: dn_rdata}, ts: r_now};
   assign w_age        = r_now - w_head.ts;
   assign w_release    = ~w_fifo_empty & (w_age >= RD) & ~reset;

   assign up_rvalid = w_bypass | w_release;
   assign up_rdata  = w_bypass  ? dn_rdata :
                      w_release ? w_head.rsp.rdata : r_rdata_hold;
   assign protocol_error = r_perr;

   tb_obi_response_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .W     ($bits(rsp_entry_t))
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .i_push  (w_push),
      .i_data  (w_push_entry),
      .i_pop   (w_release),
      .o_head  (w_head),
      .o_count (w_fifo_count),
      .o_empty (w_fifo_empty)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_lfsr       <= SEED;
         r_now        <= '0;
         r_outst      <= '0;
         r_perr       <= 1'b0;
         r_rdata_hold <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_lfsr  <= lfsr_next(r_lfsr);
         r_now   <= r_now + 16'd1;
         r_outst <= r_outst + 5'(w_accept) - 5'(up_rvalid);
         r_perr  <= r_perr | w_perr_fsm | w_stale;
         if (up_rvalid) r_rdata_hold <= up_rdata;
      end
   end

endmodule

// File: tb/tb_tb_obi_delay.sv
// Bench for the OBI latency injector: four configurations, each behind a zero-wait RAM model.
module tb_tb_obi_delay;

   localparam int N = 4;
   // per-instance configuration, instance g in bits [g*16 +: 16]
   localparam logic [63:0] GD_L  = {16'd7,  16'd0, 16'd3, 16'd0};
   localparam logic [63:0] RV_L  = {16'd10, 16'd5, 16'd4, 16'd0};
   localparam logic [63:0] MO_L  = {16'd16, 16'd2, 16'd2, 16'd2};
   localparam logic [3:0]  RND_L = 4'b1000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0] rst, up_req, up_we, up_gnt, up_rvalid;
   logic [N-1:0] dn_req, dn_we, dn_gnt, dn_rvalid, perr, inj;
   logic [31:0]  up_addr [N];
   logic [31:0]  up_wdata[N];
   logic [31:0]  up_rdata[N];
   logic [31:0]  dn_addr [N];
   logic [31:0]  dn_wdata[N];
   logic [31:0]  dn_rdata[N];
   logic [3:0]   up_be   [N];
   logic [3:0]   dn_be   [N];
   logic         mem_init;
   logic [31:0]  shadow  [N][256];
   logic [15:0]  m_lfsr;

   int cyc   = 0;
   int n_chk = 0;
   int n_err = 0;
   int rel3  = 0;

   typedef struct {
      int          k;
      logic [31:0] data;
      int          due;
   } exp_t;
   exp_t exp_q[$];

   function automatic logic [31:0] init_word(input int g, input int i);
      return {4'hA, 4'(g), 8'(i), ~8'(i), 8'h5C};
   endfunction

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
   endfunction

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) m_lfsr <= rst[3] ? 16'hACE1 : lfsr_step(m_lfsr);

   for (genvar g = 0; g < N; g++) begin : g_inst
      logic [31:0] mem [256];
      logic        rv;
      logic [31:0] rd;

      tb_obi_delay #(
         .GNT_DELAY       (int'(GD_L[g*16 +: 16])),
         .RVALID_DELAY    (int'(RV_L[g*16 +: 16])),
         .MAX_OUTSTANDING (int'(MO_L[g*16 +: 16])),
         .RANDOM          (int'(RND_L[g])),
         .SEED            (16'hACE1)
      ) u_dut (
         .clock          (clk),
         .reset          (rst[g]),
         .up_req         (up_req[g]),
         .up_addr        (up_addr[g]),
         .up_we          (up_we[g]),
         .up_be          (up_be[g]),
         .up_wdata       (up_wdata[g]),
         .up_gnt         (up_gnt[g]),
         .up_rdata       (up_rdata[g]),
         .up_rvalid      (up_rvalid[g]),
         .dn_req         (dn_req[g]),
         .dn_addr        (dn_addr[g]),
         .dn_we          (dn_we[g]),
         .dn_be          (dn_be[g]),
         .dn_wdata       (dn_wdata[g]),
         .dn_gnt         (dn_gnt[g]),
         .dn_rdata       (dn_rdata[g]),
         .dn_rvalid      (dn_rvalid[g]),
         .protocol_error (perr[g])
      );

      assign dn_gnt[g]    = 1'b1;
      assign dn_rvalid[g] = rv | inj[g];
      assign dn_rdata[g]  = inj[g] ? 32'hBAD0_0000 : rd;

      always @(posedge clk) begin
         rv <= 1'b0;
         if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(g, i);
         end else if (dn_req[g] && dn_gnt[g]) begin
            rv <= 1'b1;
            rd <= 32'd0;
            if (dn_we[g]) begin
               for (int b = 0; b < 4; b++)
                  if (dn_be[g][b]) mem[dn_addr[g][9:2]][8*b +: 8] <= dn_wdata[g][8*b +: 8];
            end else begin
               rd <= mem[dn_addr[g][9:2]];
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Scoreboard: every up_rvalid must match the oldest expected response in data and cycle.
   always @(negedge clk) begin
      exp_t e;
      for (int k = 0; k < N; k++) begin
         if (up_rvalid[k] === 1'b1) begin
            if (exp_q.size() == 0 || exp_q[0].k != k) begin
               chk($sformatf("unexpected_rvalid_%0d", k), {31'd0, up_rvalid[k]}, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk($sformatf("rdata_%0d", k), up_rdata[k], e.data);
               chk($sformatf("rvalid_cycle_%0d", k), 32'(cyc), 32'(e.due));
            end
         end
      end
   end

   task automatic issue(input int k, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wdata,
                        output int wt, output logic [7:0] lf);
      logic [31:0] expd;
      int idx;
      up_req[k]   = 1'b1;
      up_we[k]    = we;
      up_addr[k]  = addr;
      up_be[k]    = be;
      up_wdata[k] = wdata;
      wt = 0;
      @(negedge clk);
      lf = m_lfsr[7:0];
      while (up_gnt[k] !== 1'b1 && wt < 200) begin
         @(negedge clk);
         wt++;
      end
      if (up_gnt[k] !== 1'b1) begin
         chk($sformatf("gnt_timeout_%0d", k), {31'd0, up_gnt[k]}, 32'd1);
      end else begin
         idx = int'(addr[9:2]);
         expd = 32'd0;
         if (we) begin
            for (int b = 0; b < 4; b++)
               if (be[b]) shadow[k][idx][8*b +: 8] = wdata[8*b +: 8];
         end else begin
            expd = shadow[k][idx];
         end
         exp_q.push_back('{k: k, data: expd, due: cyc + 1 + int'(RV_L[k*16 +: 16])});
      end
      @(posedge clk);
      #1;
      up_req[k] = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int wt;
      int n_rv;
      logic [7:0] lf;
      logic [7:0] dexp;

      rst      = '1;
      up_req   = '0;
      up_we    = '0;
      inj      = '0;
      mem_init = 1'b1;
      for (int k = 0; k < N; k++) begin
         up_addr[k]  = '0;
         up_wdata[k] = '0;
         up_be[k]    = '0;
         for (int i = 0; i < 256; i++) shadow[k][i] = init_word(k, i);
      end

      // outputs held quiet during reset even with a request present
      repeat (2) @(posedge clk);
      #1;
      up_req[0] = 1'b1;
      @(negedge clk);
      chk("rst_up_gnt", {31'd0, up_gnt[0]}, 32'd0);
      chk("rst_dn_req", {31'd0, dn_req[0]}, 32'd0);
      chk("rst_up_rvalid", {31'd0, up_rvalid[0]}, 32'd0);
      @(posedge clk);
      #1;
      up_req[0] = 1'b0;
      rst       = '0;
      mem_init  = 1'b0;
      rel3      = cyc;
      @(negedge clk);
      chk("rst_up_rdata", up_rdata[0], 32'd0);
      chk("rst_perr", 32'(perr), 32'd0);
      @(posedge clk);
      #1;

      // zero delay: back-to-back reads, one grant per cycle, bypass response
      for (int i = 0; i < 4; i++) begin
         issue(0, 1'b0, 32'h100 + 32'(4 * i), 4'hF, 32'd0, wt, lf);
         chk("t1_gnt_wait", 32'(wt), 32'd0);
      end
      drain("t1_drain");

      // response with nothing outstanding is dropped and flagged
      inj[0] = 1'b1;
      @(negedge clk);
      chk("stale0_no_rvalid", {31'd0, up_rvalid[0]}, 32'd0);
      @(posedge clk);
      #1;
      inj[0] = 1'b0;
      @(negedge clk);
      chk("stale0_perr", {31'd0, perr[0]}, 32'd1);
      @(posedge clk);
      #1;

      // fixed grant delay of 3, partial write then read-back
      issue(1, 1'b1, 32'h200, 4'b0011, 32'hDEADBEEF, wt, lf);
      chk("t2_wr_gnt_wait", 32'(wt), 32'd3);
      issue(1, 1'b0, 32'h200, 4'hF, 32'd0, wt, lf);
      chk("t2_rd_gnt_wait", 32'(wt), 32'd3);
      drain("t2_drain");

      // reset with one response buffered and one request in WAIT
      issue(1, 1'b0, 32'h104, 4'hF, 32'd0, wt, lf);
      up_req[1]  = 1'b1;
      up_addr[1] = 32'h108;
      up_we[1]   = 1'b0;
      @(posedge clk);
      #1;
      rst[1]    = 1'b1;
      up_req[1] = 1'b0;
      exp_q.delete();
      @(posedge clk);
      #1;
      rst[1] = 1'b0;
      n_rv = 0;
      repeat (10) begin
         @(negedge clk);
         if (up_rvalid[1] === 1'b1) n_rv++;
      end
      chk("t5_no_rvalid_after_rst", 32'(n_rv), 32'd0);
      chk("t5_perr_cleared", {31'd0, perr[1]}, 32'd0);
      @(posedge clk);
      #1;
      inj[1] = 1'b1;
      @(negedge clk);
      chk("t5_late_no_rvalid", {31'd0, up_rvalid[1]}, 32'd0);
      @(posedge clk);
      #1;
      inj[1] = 1'b0;
      @(negedge clk);
      chk("t5_late_perr", {31'd0, perr[1]}, 32'd1);
      @(posedge clk);
      #1;
      issue(1, 1'b0, 32'h10C, 4'hF, 32'd0, wt, lf);
      chk("t5_fresh_gnt_wait", 32'(wt), 32'd3);
      drain("t5_drain");

      // outstanding limit of 2 with 5-cycle response delay
      issue(2, 1'b0, 32'h100, 4'hF, 32'd0, wt, lf);
      chk("t3_gnt0_wait", 32'(wt), 32'd0);
      issue(2, 1'b0, 32'h104, 4'hF, 32'd0, wt, lf);
      chk("t3_gnt1_wait", 32'(wt), 32'd0);
      issue(2, 1'b0, 32'h108, 4'hF, 32'd0, wt, lf);
      chk("t3_gnt2_wait", 32'(wt), 32'd5);
      drain("t3_drain");

      // random grant delays against the LFSR draw
      for (int i = 0; i < 200; i++) begin
         int gap;
         issue(3, 1'($urandom_range(0, 1)), {22'd0, 8'($urandom_range(0, 255)), 2'b00},
               4'($urandom_range(1, 15)), $urandom, wt, lf);
         dexp = (lf < 8'd7) ? lf : 8'd7;
         chk("t4_gnt_wait", 32'(wt), 32'(dexp));
         gap = $urandom_range(0, 2);
         if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
         end
      end
      drain("t4_drain");
      chk("t4_perr", {31'd0, perr[3]}, 32'd0);

      // responses straddling the 16-bit timestamp wrap
      while (cyc - rel3 < 65524) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) issue(3, 1'b0, 32'h300 + 32'(4 * i), 4'hF, 32'd0, wt, lf);
      drain("t6_drain");

      chk("final_perr", 32'(perr), 32'h3);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
